spi_xfer_ctrl_mopshub: RTL and testbench

- Transaction controller sitting directly upstream of the byte-level SPI master.
- Accepts a multi-byte SPI transfer request (1..MAX_BYTES bytes, MSB byte first), feeds bytes one at a time over the master's cs/wr/rd/addr bus, and collects the byte shifted in for each byte sent.
- Drives the slave-select line around the whole transaction and reports completion with a one-cycle done pulse.

---
 rtl/spi_xfer_ctrl_mopshub_if.sv | 37 +++
 rtl/spi_xfer_ctrl_mopshub.sv | 246 ++++++++++++++++++++++++
 tb/tb_spi_xfer_ctrl_mopshub.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_ctrl_mopshub_if.sv
// rtl/spi_xfer_ctrl_mopshub_if.sv - command bus between the transfer controller and the byte-level SPI master
//
// Purpose: carries the strobed command bus that the controller uses to feed bytes to the SPI master.
// Signals:
//   m_cs    chip select, high only together with m_wr or m_rd
//   m_wr    one-cycle write strobe (byte in m_wdata)
//   m_rd    one-cycle read strobe (byte returned on m_rdata)
//   m_addr  command address, 2'b00 selects the data register
//   m_wdata byte sent to the master
//   m_rdata combinational read data from the master
// Modports: master = controller side (drives the strobes), slave = SPI master side.
interface spi_xfer_ctrl_mopshub_if;
  logic       m_cs;
  logic       m_wr;
  logic       m_rd;
  logic [1:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_rdata;

  modport master (
    output m_cs,
    output m_wr,
    output m_rd,
    output m_addr,
    output m_wdata,
    input  m_rdata
  );

  modport slave (
    input  m_cs,
    input  m_wr,
    input  m_rd,
    input  m_addr,
    input  m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/spi_xfer_ctrl_mopshub.sv
// rtl/spi_xfer_ctrl_mopshub.sv - multi-byte SPI transaction controller in front of a byte-level SPI master
//
// Purpose: accepts a 1..MAX_BYTES byte request, frames it with ssel_n, writes each byte to the
// SPI master, waits for the shift, reads the received byte back, and pulses done at the end.
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   start      one-cycle request, honoured only in IDLE
//   nbytes     byte count (1..MAX_BYTES), sampled with start
//   tx_data    bytes to send, byte 0 in the top byte, sampled with start
//   busy       high from the cycle after an accepted start until done
//   done       one-cycle completion pulse
//   err        one-cycle pulse for a start with an illegal byte count
//   rx_data    received bytes, byte 0 in the top byte, unused bytes zero
//   ssel_n     active-low slave select framing the whole transaction
//   bus        command bus to the SPI master (master modport)
module spi_xfer_ctrl_mopshub #(
  parameter int MAX_BYTES   = 4,
  parameter int DIV         = 0,
  parameter int XFER_CYCLES = 18 * (DIV + 1) + 4,
  parameter int SS_GUARD    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             nbytes,
  input  logic [8*MAX_BYTES-1:0] tx_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [8*MAX_BYTES-1:0] rx_data,
  output logic                   ssel_n,
  spi_xfer_ctrl_mopshub_if.master bus
);

  localparam int DW   = 8 * MAX_BYTES;
  localparam int CMAX = (XFER_CYCLES > SS_GUARD) ? XFER_CYCLES : SS_GUARD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  // Counters are loaded with N-1 and the state is left when they reach zero,
  // so each wait lasts exactly N cycles. SS_GUARD must be at least 1.
  localparam logic [CW-1:0] XFER_LOAD  = CW'(XFER_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_LOAD = CW'(SS_GUARD - 1);
  localparam logic [3:0]    MAX_NB     = 4'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SS_SETUP,
    S_LOAD,
    S_WAIT_TX,
    S_READ,
    S_DRAIN,
    S_SS_HOLD,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [2:0]      nb_q, nb_d;
  logic [DW-1:0]   tx_q, tx_d;
  logic [DW-1:0]   rx_q, rx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            ssel_n_q, ssel_n_d;
  logic            cs_q, cs_d;
  logic            wr_q, wr_d;
  logic            rd_q, rd_d;
  logic [1:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;

  logic            nb_ok;
  logic            is_last;

  // Byte k of a word, byte 0 being the most significant.
  function automatic logic [7:0] byte_of(input logic [DW-1:0] v, input logic [IW-1:0] k);
    logic [DW-1:0] s;
    s = v << {k, 3'b000};
    return s[DW-1 -: 8];
  endfunction

  assign nb_ok   = (nbytes != 3'd0) && ({1'b0, nbytes} <= MAX_NB);
  assign is_last = (int'(idx_q) == int'(nb_q) - 1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    nb_d     = nb_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    ssel_n_d = ssel_n_q;
    cs_d     = 1'b0;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    addr_d   = 2'b00;
    wdata_d  = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (nb_ok) begin
            tx_d     = tx_data;
            nb_d     = nbytes;
            rx_d     = '0;
            idx_d    = '0;
            ssel_n_d = 1'b0;
            busy_d   = 1'b1;
            cnt_d    = GUARD_LOAD;
            state_d  = S_SS_SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      // Strobes are registered: the write for a byte is requested on the
      // transition so that m_wr is high exactly while the state is LOAD.
      S_SS_SETUP: begin
        if (cnt_q == '0) begin
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          wdata_d = byte_of(tx_q, idx_q);
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_LOAD: begin
        cnt_d   = XFER_LOAD;
        state_d = S_WAIT_TX;
      end

      S_WAIT_TX: begin
        if (cnt_q == '0) begin
          cs_d    = 1'b1;
          rd_d    = 1'b1;
          state_d = S_READ;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      // m_rd is high this cycle, so m_rdata holds the byte shifted in for byte idx.
      // The master also starts a dummy shift for the idle read, hence the drain wait.
      S_READ: begin
        for (int b = 0; b < MAX_BYTES; b++) begin
          if (idx_q == IW'(b)) begin
            rx_d[DW-1-8*b -: 8] = bus.m_rdata;
          end
        end
        cnt_d   = XFER_LOAD;
        state_d = S_DRAIN;
      end

      S_DRAIN: begin
        if (cnt_q == '0) begin
          if (is_last) begin
            cnt_d   = GUARD_LOAD;
            state_d = S_SS_HOLD;
          end else begin
            idx_d   = idx_q + IW'(1);
            cs_d    = 1'b1;
            wr_d    = 1'b1;
            wdata_d = byte_of(tx_q, idx_q + IW'(1));
            state_d = S_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_SS_HOLD: begin
        if (cnt_q == '0) begin
          ssel_n_d = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      nb_q     <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ssel_n_q <= 1'b1;
      cs_q     <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= 2'b00;
      wdata_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      nb_q     <= nb_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ssel_n_q <= ssel_n_d;
      cs_q     <= cs_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rx_data     = rx_q;
  assign ssel_n      = ssel_n_q;
  assign bus.m_cs    = cs_q;
  assign bus.m_wr    = wr_q;
  assign bus.m_rd    = rd_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;

endmodule

// File: tb/tb_spi_xfer_ctrl_mopshub.sv
// tb/tb_spi_xfer_ctrl_mopshub.sv - directed self-checking bench for spi_xfer_ctrl_mopshub
module tb_spi_xfer_ctrl_mopshub;
  localparam int MAX_BYTES = 4;
  localparam int XFER      = 22;          // 18*(DIV+1)+4 with DIV=0
  localparam int LAT1      = 52;          // 1+2+1+22+1+22+2+1, start cycle to done cycle inclusive
  localparam int LAT_BYTE  = 46;          // 2*22+2 per additional byte

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  nbytes = 3'd0;
  logic [31:0] tx_data = 32'h0;
  logic        busy, done, err, ssel_n;
  logic [31:0] rx_data;

  spi_xfer_ctrl_mopshub_if bus();

  spi_xfer_ctrl_mopshub #(.MAX_BYTES(MAX_BYTES), .DIV(0), .SS_GUARD(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .nbytes  (nbytes),
    .tx_data (tx_data),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .rx_data (rx_data),
    .ssel_n  (ssel_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model: constant byte, or echo of the byte written before the current one.
  int         rd_mode = 0;
  logic [7:0] const_r = 8'h00;
  int         echo_base = 0;
  int         wr_cnt = 0, rd_cnt = 0, done_cnt = 0, err_cnt = 0, viol = 0, gap = 1000;
  logic       prev_strobe = 1'b0;
  logic [7:0] wr_log [16];
  logic [7:0] rdata;

  always_comb begin
    rdata = 8'h00;
    if (rd_mode == 0) rdata = const_r;
    else if (wr_cnt - echo_base >= 2) rdata = wr_log[(wr_cnt - 2) % 16];
  end
  assign bus.m_rdata = rdata;

  // Protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin : mon
    logic s;
    int   v;
    if (!rst) begin
      s = bus.m_wr | bus.m_rd;
      v = 0;
      if (bus.m_cs !== s) v++;
      if (bus.m_wr && bus.m_rd) v++;
      if (s && bus.m_addr !== 2'b00) v++;
      if (s && prev_strobe) v++;
      if (s && (gap + 1 < XFER)) v++;
      if (busy && ssel_n) v++;
      viol <= viol + v;
      gap <= s ? 0 : gap + 1;
      if (bus.m_wr) begin
        wr_log[wr_cnt % 16] <= bus.m_wdata;
        wr_cnt <= wr_cnt + 1;
      end
      if (bus.m_rd) rd_cnt <= rd_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (err) err_cnt <= err_cnt + 1;
      prev_strobe <= s;
    end else begin
      prev_strobe <= 1'b0;
    end
  end

  // Issue one transaction and wait for done; optionally pulse a stray start once
  // the given number of write strobes has been seen.
  task automatic run_xfer(input logic [2:0] nb, input logic [31:0] tx, input int poke_wr, output int lat);
    int n;
    int base;
    bit poked;
    @(posedge clk); #1;
    start = 1'b1; nbytes = nb; tx_data = tx;
    base = wr_cnt; n = 0; poked = 0;
    do begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (poke_wr > 0 && !poked && (wr_cnt - base == poke_wr)) begin
        start = 1'b1; nbytes = 3'd1; tx_data = 32'hFFFF_FFFF; poked = 1;
      end
    end while (!done && n < 2000);
    start = 1'b0;
    check("done_seen", {63'b0, done}, 64'd1);
    lat = n + 1;
  endtask

  initial begin
    int lat, n, base, sbase, dbase, ebase;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  {63'b0, busy},   64'd0);
    check("rst_done",  {63'b0, done},   64'd0);
    check("rst_err",   {63'b0, err},    64'd0);
    check("rst_ssel",  {63'b0, ssel_n}, 64'd1);
    check("rst_cs",    {63'b0, bus.m_cs}, 64'd0);
    check("rst_addr",  {62'b0, bus.m_addr}, 64'd0);
    check("rst_wdata", {56'b0, bus.m_wdata}, 64'd0);
    check("rst_rx",    {32'b0, rx_data}, 64'd0);
    rst = 1'b0;

    // Async reset in WAIT_TX of byte 1 of a 4-byte transfer
    rd_mode = 0; const_r = 8'h3C;
    @(posedge clk); #1;
    start = 1'b1; nbytes = 3'd4; tx_data = 32'hDEAD_BEEF;
    base = wr_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (wr_cnt - base < 2 && n < 500) begin
      @(posedge clk); #1; n++;
    end
    check("arst_reach_byte1", wr_cnt - base, 64'd2);
    repeat (5) @(posedge clk);
    #1;
    check("arst_busy_before", {63'b0, busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",  {63'b0, busy},       64'd0);
    check("arst_ssel",  {63'b0, ssel_n},     64'd1);
    check("arst_cs",    {63'b0, bus.m_cs},   64'd0);
    check("arst_rd",    {63'b0, bus.m_rd},   64'd0);
    check("arst_wdata", {56'b0, bus.m_wdata}, 64'd0);
    check("arst_rx",    {32'b0, rx_data},    64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    sbase = wr_cnt + rd_cnt;
    repeat (100) @(posedge clk);
    #1;
    check("arst_no_strobes", wr_cnt + rd_cnt - sbase, 64'd0);
    check("arst_idle_busy", {63'b0, busy}, 64'd0);

    // Single byte
    base = wr_cnt; sbase = rd_cnt;
    run_xfer(3'd1, 32'hA500_0000, 0, lat);
    check("b1_latency", lat, LAT1);
    check("b1_ssel_at_done", {63'b0, ssel_n}, 64'd1);
    check("b1_wr_count", wr_cnt - base, 64'd1);
    check("b1_rd_count", rd_cnt - sbase, 64'd1);
    check("b1_wdata", {56'b0, wr_log[base % 16]}, 64'h A5);
    check("b1_rx", {32'b0, rx_data}, 64'h3C00_0000);

    // Four bytes, slave echoes the previous byte
    rd_mode = 1; echo_base = wr_cnt; base = wr_cnt;
    run_xfer(3'd4, 32'h1122_3344, 0, lat);
    check("b4_latency", lat, LAT1 + 3 * LAT_BYTE);
    check("b4_wr_count", wr_cnt - base, 64'd4);
    check("b4_wdata_order", {32'b0, wr_log[base % 16], wr_log[(base + 1) % 16],
                             wr_log[(base + 2) % 16], wr_log[(base + 3) % 16]}, 64'h1122_3344);
    check("b4_rx", {32'b0, rx_data}, 64'h0011_2233);

    // Illegal byte counts
    rd_mode = 0;
    sbase = wr_cnt + rd_cnt; ebase = err_cnt;
    @(posedge clk); #1; start = 1'b1; nbytes = 3'd0;
    @(posedge clk); #1; start = 1'b0;
    check("nb0_err", {63'b0, err}, 64'd1);
    check("nb0_busy", {63'b0, busy}, 64'd0);
    @(posedge clk); #1;
    check("nb0_err_pulse", {63'b0, err}, 64'd0);
    start = 1'b1; nbytes = 3'd5;
    @(posedge clk); #1; start = 1'b0;
    check("nb5_err", {63'b0, err}, 64'd1);
    check("nb5_busy", {63'b0, busy}, 64'd0);
    repeat (5) @(posedge clk);
    #1;
    check("bad_nb_no_strobes", wr_cnt + rd_cnt - sbase, 64'd0);
    check("bad_nb_err_count", err_cnt - ebase, 64'd2);
    check("bad_nb_rx_kept", {32'b0, rx_data}, 64'h0011_2233);

    // Start while busy is ignored, then a back-to-back start after done
    const_r = 8'h5A; dbase = done_cnt; ebase = err_cnt; base = wr_cnt;
    run_xfer(3'd3, 32'hAABB_CC00, 2, lat);
    check("busy_start_latency", lat, LAT1 + 2 * LAT_BYTE);
    check("busy_start_rx", {32'b0, rx_data}, 64'h5A5A_5A00);
    check("busy_start_wdata", {40'b0, wr_log[base % 16], wr_log[(base + 1) % 16],
                               wr_log[(base + 2) % 16]}, 64'hAABBCC);
    base = wr_cnt;
    run_xfer(3'd1, 32'h7700_0000, 0, lat);
    check("b2b_latency", lat, LAT1);
    check("b2b_wdata", {56'b0, wr_log[base % 16]}, 64'h77);
    check("b2b_rx", {32'b0, rx_data}, 64'h5A00_0000);
    repeat (150) @(posedge clk);
    #1;
    check("busy_start_done_count", done_cnt - dbase, 64'd2);
    check("busy_start_no_err", err_cnt - ebase, 64'd0);
    check("final_busy", {63'b0, busy}, 64'd0);

    check("protocol_violations", viol, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
